// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link: state encoding, default
// sizing and the reference patterns used by the detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LEN_W = 4;
  localparam int unsigned DEF_REP_W = 4;
  localparam int unsigned DEF_GAP   = 2;

  localparam logic [3:0] PAT_1101 = 4'b1101;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
module down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: shifts a captured frame out MSB-first, repeats it
// reps+1 times with GAP idle cycles after each copy, then pulses done.
module seq_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned REP_W = DEF_REP_W,
  parameter int unsigned GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  state_t           state;
  logic [WIDTH-1:0] frame;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] idx_val;
  logic [LEN_W-1:0] idx_count;
  logic [GAP_W-1:0] gap_count;
  logic [REP_W-1:0] rep_count;
  logic             idx_load, idx_en, idx_zero;
  logic             gap_load, gap_en, gap_zero;
  logic             rep_zero;
  logic             accept, frame_end, gap_end, reload, cur_bit;
  logic             unused_counts;

  // Counter controls are decoded from the current state so the counters and
  // the FSM advance on the same edge; the FSM only reads their zero flags.
  always_comb begin
    len_clamp = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    accept    = (state == ST_IDLE) && start && (len != '0);
    frame_end = (state == ST_SHIFT) && idx_zero;
    gap_end   = (state == ST_GAP) && gap_zero;
    reload    = !rep_zero && ((frame_end && (GAP == 0)) || gap_end);
    idx_load  = accept || reload;
    idx_val   = accept ? (len_clamp - LEN_W'(1)) : (len_q - LEN_W'(1));
    idx_en    = (state == ST_SHIFT) && !idx_zero;
    gap_load  = frame_end;
    gap_en    = (state == ST_GAP) && !gap_zero;
    cur_bit   = |(frame & (WIDTH'(1) << idx_count));
  end

  down_counter #(.W(LEN_W)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .load  (idx_load),
    .en    (idx_en),
    .value (idx_val),
    .count (idx_count),
    .zero  (idx_zero)
  );

  down_counter #(.W(GAP_W)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .load  (gap_load),
    .en    (gap_en),
    .value (GAP_W'(GAP_LOAD)),
    .count (gap_count),
    .zero  (gap_zero)
  );

  down_counter #(.W(REP_W)) u_rep (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .en    (reload),
    .value (reps),
    .count (rep_count),
    .zero  (rep_zero)
  );

  assign unused_counts = ^{gap_count, rep_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame     <= '0;
      len_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          if (accept) begin
            frame <= data;
            len_q <= len_clamp;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          out       <= cur_bit;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          if (idx_zero) begin
            if (GAP > 0)       state <= ST_GAP;
            else if (rep_zero) state <= ST_DONE;
          end
        end
        ST_GAP: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b1;
          if (gap_zero) state <= rep_zero ? ST_DONE : ST_SHIFT;
        end
        ST_DONE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: table of frames plus hand-written corner sequences, with a
// per-cycle scoreboard of {out, out_valid, busy, done}.
module tb_seq_tx;
  import seq_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned REP_W = 4;
  localparam int unsigned GAP   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_a, start_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic [LEN_W-1:0] len_a, len_b;
  logic [REP_W-1:0] reps_a, reps_b;
  logic             out_a, valid_a, busy_a, done_a;
  logic             out_b, valid_b, busy_b, done_b;

  always #5 clk = ~clk;

  seq_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a), .len(len_a), .reps(reps_a),
    .out(out_a), .out_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  seq_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b), .len(len_b), .reps(reps_b),
    .out(out_b), .out_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] reps;
    logic [7:0] exp_bits;
    int         exp_n;
    int         exp_done;
    int         poke;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] exp_q[$];
  int         passed = 0;
  int         total  = 0;
  int         d;

  function automatic logic [3:0] obs(input int which);
    return (which != 0) ? {out_b, valid_b, busy_b, done_b} : {out_a, valid_a, busy_a, done_a};
  endfunction

  task automatic check_obs(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: {out,valid,busy,done} got=%b want=%b", name, got, want);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got=%0d want=%0d", name, got, want);
  endtask

  task automatic push_frame(input logic [7:0] bits, input int n, input int reps, input int gap);
    for (int r = 0; r <= reps; r++) begin
      for (int b = n - 1; b >= 0; b--) exp_q.push_back({bits[b], 1'b1, 1'b1, 1'b0});
      for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  // Cycle i is sampled 1 time unit after the i-th rising edge following start.
  task automatic check_cycles(input int which, input int n, input string tag,
                              input int poke, output int done_at);
    logic [3:0] e;
    logic [3:0] got;
    done_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      got = obs(which);
      if (got[0] && done_at < 0) done_at = i;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL %s c%0d: scoreboard empty, got=%b", tag, i, got);
      end else begin
        e = exp_q.pop_front();
        check_obs($sformatf("%s c%0d", tag, i), got, e);
      end
      if (i == poke) begin
        start_a = 1'b1;
        data_a  = 8'hFF;
        len_a   = 4'd8;
        reps_a  = 4'd3;
      end else if (i == poke + 1) begin
        start_a = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v       = vecs[idx];
    start_a = 1'b1;
    data_a  = v.data;
    len_a   = v.len;
    reps_a  = v.reps;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    data_a  = 8'h3C;
    len_a   = 4'd7;
    reps_a  = 4'd0;
    if (v.exp_n == 0) push_idle(3);
    else begin
      push_frame(v.exp_bits, v.exp_n, int'(v.reps), GAP);
      push_idle(1);
    end
    n = exp_q.size();
    check_cycles(0, n, $sformatf("vec%0d", idx), v.poke, d);
    check_int($sformatf("vec%0d done_cycle", idx), d, v.exp_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{{4'h0, PAT_1101}, 4'd4,  4'd0,  {4'h0, PAT_1101}, 4, 7,  -1};
    vecs[1] = '{8'h0D,            4'd4,  4'd2,  8'h0D,            4, 19, -1};
    vecs[2] = '{8'hA5,            4'd12, 4'd0,  8'hA5,            8, 11, -1};
    vecs[3] = '{8'h01,            4'd1,  4'd0,  8'h01,            1, 4,  -1};
    vecs[4] = '{8'hFF,            4'd0,  4'd3,  8'h00,            0, -1, -1};
    vecs[5] = '{8'h0D,            4'd4,  4'd0,  8'h0D,            4, 7,  2};
    vecs[6] = '{8'h01,            4'd1,  4'd15, 8'h01,            1, 49, -1};
    vecs[7] = '{8'hFF,            4'd8,  4'd1,  8'hFF,            8, 21, -1};

    rst     = 1'b1;
    start_a = 1'b0; data_a = '0; len_a = '0; reps_a = '0;
    start_b = 1'b0; data_b = '0; len_b = '0; reps_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_a", obs(0), 4'b0000);
    check_obs("reset_b", obs(1), 4'b0000);
    rst = 1'b0;

    push_idle(5);
    check_cycles(0, 5, "idle", -1, d);

    foreach (vecs[i]) run_vec(i);

    // start held high: second frame must follow DONE plus one IDLE cycle
    start_a = 1'b1; data_a = 8'h01; len_a = 4'd1; reps_a = 4'd0;
    @(posedge clk);
    #1;
    push_frame(8'h01, 1, 0, GAP);
    push_idle(1);
    push_frame(8'h01, 1, 0, GAP);
    push_idle(1);
    check_cycles(0, 5, "b2b_first", -1, d);
    check_int("b2b done_cycle", d, 4);
    start_a = 1'b0;
    check_cycles(0, 5, "b2b_second", -1, d);
    check_int("b2b second done", d, 4);

    // asynchronous reset in the middle of a frame
    start_a = 1'b1; data_a = 8'hFF; len_a = 4'd8; reps_a = 4'd2;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_obs("pre_rst", obs(0), 4'b1110);
    rst = 1'b1;
    #1;
    check_obs("rst_async", obs(0), 4'b0000);
    @(posedge clk);
    #1;
    check_obs("rst_held", obs(0), 4'b0000);
    rst = 1'b0;
    push_idle(3);
    check_cycles(0, 3, "post_rst", -1, d);
    check_int("post_rst no_done", d, -1);
    run_vec(0);

    // GAP=0 build: back-to-back copies with out_valid continuously high
    start_b = 1'b1; data_b = 8'b0000_1011; len_b = 4'd4; reps_b = 4'd1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    push_frame(8'b0000_1011, 4, 1, 0);
    push_idle(1);
    check_cycles(1, 10, "gap0", -1, d);
    check_int("gap0 done_cycle", d, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
